// File: rtl/mux16_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the 16:1 mux arbiter.
// master: requester side (drives req). slave: arbiter side (drives gnt/sel/valid).
interface mux16_rr_arbiter_if #(
    parameter int unsigned N_REQ = 16,
    parameter int unsigned SEL_W = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;

    modport master (output req, input gnt, input sel, input valid);
    modport slave  (input req, output gnt, output sel, output valid);
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter in front of a 16:1 bit mux. Grants are registered and held
// while the owner keeps its request up; on release the pointer moves past the
// owner so the nearest requester above it wins, with no idle bubble.
// Optional feature: define ARB_TIMEOUT_EN to force rearbitration after HOLD_MAX
// consecutive owner cycles while another requester waits.
module mux16_rr_arbiter #(
    parameter int unsigned N_REQ    = 16,
    parameter int unsigned SEL_W    = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned HOLD_MAX = 8
`endif
) (
    input logic               clk,
    input logic               rst,
    mux16_rr_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]       cnt_q, cnt_d;
`endif

    // Returns {found, index}: first set bit of r scanning start, start+1, ... wrapping.
    function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [SEL_W-1:0] start);
        logic             found;
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        found = 1'b0;
        pick  = start;
        for (int i = 0; i < N_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

    logic [N_REQ-1:0] owner_oh;
    logic [N_REQ-1:0] others;
    logic [SEL_W-1:0] next_ptr;
    logic [SEL_W:0]   idle_pick;
    logic [SEL_W:0]   hand_pick;

    // State register and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next-state: priority search from ptr in idle, exclusion search from owner+1 on handoff.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << sel_q;
        others    = bus.req & ~owner_oh;
        next_ptr  = sel_q + 1'b1;
        idle_pick = rr_pick(bus.req, ptr_q);
        hand_pick = rr_pick(others, next_ptr);

        unique case (state_q)
            StIdle: begin
                if (idle_pick[SEL_W]) begin
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << idle_pick[SEL_W-1:0];
                    sel_d   = idle_pick[SEL_W-1:0];
                    valid_d = 1'b1;
                    state_d = StGrant;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StGrant: begin
                if (bus.req[sel_q]) begin
`ifdef ARB_TIMEOUT_EN
                    if (cnt_q == 8'(HOLD_MAX - 1)) begin
                        // Saturated: hand off only if someone else is waiting.
                        if (hand_pick[SEL_W]) begin
                            ptr_d = next_ptr;
                            gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << hand_pick[SEL_W-1:0];
                            sel_d = hand_pick[SEL_W-1:0];
                            cnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end else begin
                    ptr_d = next_ptr;
                    if (hand_pick[SEL_W]) begin
                        gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << hand_pick[SEL_W-1:0];
                        sel_d = hand_pick[SEL_W-1:0];
`ifdef ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        // sel keeps its last value so the mux select does not move.
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs come straight from registers so the mux select is glitch-free.
    always_comb begin
        bus.gnt   = gnt_q;
        bus.sel   = sel_q;
        bus.valid = valid_q;
    end

endmodule
